// File: rtl/mac_multi_ch_acc.sv
// Multi-channel MAC: one shared multiplier feeding NUM_CH accumulators through a 3-stage pipeline.
// Optional MAC_ACC_OVF_STICKY_EN adds a per-channel sticky accumulator overflow output (acc_ovf).
module mac_multi_ch_acc #(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 8,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int SEL_W   = 6
) (
  input  logic              MAC_ACC_CLK,
  input  logic              acc_ff_rstn,
  input  logic              EFPGA_MATHB_CLK_EN,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_oper,
  input  logic [DATA_W-1:0] in_coef,
  input  logic              in_tc,
  input  logic              in_clear,
  input  logic              in_rnd,
  input  logic [SEL_W-1:0]  in_out_sel,
  input  logic              in_sat,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] mac_out,
  output logic              sat_flag
`ifdef MAC_ACC_OVF_STICKY_EN
  ,
  output logic [NUM_CH-1:0] acc_ovf
`endif
);

  localparam int ACC_W = 2*DATA_W + GUARD_W;
  localparam int KMAX  = ACC_W - DATA_W;
  localparam logic [SEL_W-1:0] LP_KMAX   = SEL_W'(KMAX);
  localparam logic [CH_W:0]    LP_NUM_CH = (CH_W+1)'(NUM_CH);

  // S1: operands widened by one bit so a single signed multiply serves both modes
  logic signed [DATA_W:0]     w_a_x;
  logic signed [DATA_W:0]     w_b_x;
  logic signed [2*DATA_W+1:0] w_prod_s;
  logic [ACC_W-1:0]           w_prod;

  assign w_a_x    = {in_tc & in_oper[DATA_W-1], in_oper};
  assign w_b_x    = {in_tc & in_coef[DATA_W-1], in_coef};
  assign w_prod_s = w_a_x * w_b_x;
  assign w_prod   = ACC_W'(w_prod_s);

  logic              r_s1_vld;
  logic [CH_W-1:0]   r_s1_ch;
  logic [ACC_W-1:0]  r_s1_prod;
  logic              r_s1_tc;
  logic              r_s1_clr;
  logic              r_s1_rnd;
  logic [SEL_W-1:0]  r_s1_sel;
  logic              r_s1_sat;

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r_s1_vld  <= 1'b0;
      r_s1_ch   <= '0;
      r_s1_prod <= '0;
      r_s1_tc   <= 1'b0;
      r_s1_clr  <= 1'b0;
      r_s1_rnd  <= 1'b0;
      r_s1_sel  <= '0;
      r_s1_sat  <= 1'b0;
    end else if (EFPGA_MATHB_CLK_EN) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_ch   <= in_ch;
        r_s1_prod <= w_prod;
        r_s1_tc   <= in_tc;
        r_s1_clr  <= in_clear;
        r_s1_rnd  <= in_rnd;
        r_s1_sel  <= in_out_sel;
        r_s1_sat  <= in_sat;
      end
    end
  end

  // S2: out-of-range window select collapses to k=0 here so S3 sees a legal k
  logic [ACC_W-1:0] r_acc [NUM_CH];
  logic [SEL_W-1:0] w_k;
  logic [ACC_W-1:0] w_rb;
  logic             w_ch_ok;
  logic [ACC_W-1:0] w_acc_rd;
  logic [ACC_W-1:0] w_fb;
  logic [ACC_W-1:0] w_sum;
  logic             w_s2_upd;

  assign w_k      = (r_s1_sel > LP_KMAX) ? '0 : r_s1_sel;
  assign w_rb     = (w_k == '0) ? '0 : (ACC_W'(1) << (w_k - SEL_W'(1)));
  assign w_ch_ok  = ({1'b0, r_s1_ch} < LP_NUM_CH);
  assign w_acc_rd = w_ch_ok ? r_acc[r_s1_ch] : '0;
  assign w_fb     = r_s1_clr ? '0 : (r_s1_rnd ? w_rb : w_acc_rd);
  assign w_sum    = r_s1_prod + w_fb;
  assign w_s2_upd = EFPGA_MATHB_CLK_EN & r_s1_vld;

`ifdef MAC_ACC_OVF_STICKY_EN
  logic              w_ovf;
  logic [NUM_CH-1:0] r_acc_ovf;

  assign w_ovf = r_s1_tc ? ((r_s1_prod[ACC_W-1] == w_fb[ACC_W-1]) &&
                            (w_sum[ACC_W-1] != r_s1_prod[ACC_W-1]))
                         : (w_sum < r_s1_prod);
  assign acc_ovf = r_acc_ovf;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
      if (!acc_ff_rstn) begin
        r_acc[c] <= '0;
      end else if (w_s2_upd && (r_s1_ch == CH_W'(c))) begin
        r_acc[c] <= w_sum;
      end
    end

`ifdef MAC_ACC_OVF_STICKY_EN
    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
      if (!acc_ff_rstn) begin
        r_acc_ovf[c] <= 1'b0;
      end else if (w_s2_upd && (r_s1_ch == CH_W'(c))) begin
        if (w_ovf) begin
          r_acc_ovf[c] <= 1'b1;
        end else if (r_s1_clr) begin
          r_acc_ovf[c] <= 1'b0;
        end
      end
    end
`endif
  end

  logic              r_s2_vld;
  logic [CH_W-1:0]   r_s2_ch;
  logic [ACC_W-1:0]  r_s2_acc;
  logic              r_s2_tc;
  logic [SEL_W-1:0]  r_s2_k;
  logic              r_s2_sat;

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r_s2_vld <= 1'b0;
      r_s2_ch  <= '0;
      r_s2_acc <= '0;
      r_s2_tc  <= 1'b0;
      r_s2_k   <= '0;
      r_s2_sat <= 1'b0;
    end else if (EFPGA_MATHB_CLK_EN) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_ch  <= r_s1_ch;
        r_s2_acc <= w_sum;
        r_s2_tc  <= r_s1_tc;
        r_s2_k   <= w_k;
        r_s2_sat <= r_s1_sat;
      end
    end
  end

  // S3: window extraction; the fit checks look at everything above the window
  logic [DATA_W-1:0]       w_win;
  logic signed [ACC_W-1:0] w_hi_s;
  logic [ACC_W-1:0]        w_hi_u;
  logic                    w_fit;
  logic [DATA_W-1:0]       w_clamp;
  logic                    w_do_sat;

  assign w_win    = DATA_W'(r_s2_acc >> r_s2_k);
  assign w_hi_s   = $signed(r_s2_acc) >>> (32'(r_s2_k) + DATA_W - 1);
  assign w_hi_u   = r_s2_acc >> (32'(r_s2_k) + DATA_W);
  assign w_fit    = r_s2_tc ? ((w_hi_s == '0) || (w_hi_s == '1)) : (w_hi_u == '0);
  assign w_clamp  = !r_s2_tc ? '1 :
                    (r_s2_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}});
  assign w_do_sat = r_s2_sat & ~w_fit;

  logic              r_out_vld;
  logic [CH_W-1:0]   r_out_ch;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sat;

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r_out_vld  <= 1'b0;
      r_out_ch   <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (EFPGA_MATHB_CLK_EN) begin
      r_out_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_out_ch   <= r_s2_ch;
        r_out_data <= w_do_sat ? w_clamp : w_win;
        r_out_sat  <= w_do_sat;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_ch    = r_out_ch;
  assign mac_out   = r_out_data;
  assign sat_flag  = r_out_sat;

endmodule

// File: tb/tb_mac_multi_ch_acc.sv
// Directed self-checking bench for mac_multi_ch_acc at default parameters.
module tb_mac_multi_ch_acc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [15:0] in_oper;
  logic [15:0] in_coef;
  logic        in_tc;
  logic        in_clear;
  logic        in_rnd;
  logic [5:0]  in_out_sel;
  logic        in_sat;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [15:0] mac_out;
  logic        sat_flag;
`ifdef MAC_ACC_OVF_STICKY_EN
  logic [3:0]  acc_ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mac_multi_ch_acc dut (
    .MAC_ACC_CLK        (clk),
    .acc_ff_rstn        (rstn),
    .EFPGA_MATHB_CLK_EN (en),
    .in_valid           (in_valid),
    .in_ch              (in_ch),
    .in_oper            (in_oper),
    .in_coef            (in_coef),
    .in_tc              (in_tc),
    .in_clear           (in_clear),
    .in_rnd             (in_rnd),
    .in_out_sel         (in_out_sel),
    .in_sat             (in_sat),
    .out_valid          (out_valid),
    .out_ch             (out_ch),
    .mac_out            (mac_out),
    .sat_flag           (sat_flag)
`ifdef MAC_ACC_OVF_STICKY_EN
    ,
    .acc_ovf            (acc_ovf)
`endif
  );

  // Saturation vectors, all on ch2 with clear
  localparam logic [15:0] SAT_A  [5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hFFFF};
  localparam logic [15:0] SAT_B  [5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFF};
  localparam logic        SAT_TC [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [5:0]  SAT_K  [5] = '{6'd0, 6'd15, 6'd0, 6'd0, 6'd0};
  localparam logic        SAT_S  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [15:0] SAT_Q  [5] = '{16'h7FFF, 16'h7FFE, 16'h0001, 16'h8000, 16'hFFFF};
  localparam logic        SAT_F  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  // Round-bias vectors, unsigned on ch3 with rnd
  localparam logic [15:0] RND_A  [5] = '{16'h0018, 16'h0018, 16'h0018, 16'hFFFF, 16'h0018};
  localparam logic [15:0] RND_B  [5] = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001};
  localparam logic        RND_C  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [5:0]  RND_K  [5] = '{6'd4, 6'd4, 6'd30, 6'd24, 6'd1};
  localparam logic [15:0] RND_Q  [5] = '{16'h0002, 16'h0001, 16'h0018, 16'h0100, 16'h000C};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] b,
                        input logic tc, input logic clr, input logic rnd,
                        input logic [5:0] k, input logic sat);
    in_valid   = 1'b1;
    in_ch      = ch;
    in_oper    = a;
    in_coef    = b;
    in_tc      = tc;
    in_clear   = clr;
    in_rnd     = rnd;
    in_out_sel = k;
    in_sat     = sat;
  endtask

  task automatic set_idle();
    in_valid   = 1'b0;
    in_ch      = 2'd0;
    in_oper    = 16'h0000;
    in_coef    = 16'h0000;
    in_tc      = 1'b0;
    in_clear   = 1'b0;
    in_rnd     = 1'b0;
    in_out_sel = 6'd0;
    in_sat     = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b1;
    set_idle();
    #12;
    n_chk++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0)
      $display("FAIL reset_ctl: got v=%0b ch=%0d, want v=0 ch=0", out_valid, out_ch);
    else n_pass++;
    n_chk++;
    if (mac_out !== 16'h0000 || sat_flag !== 1'b0)
      $display("FAIL reset_data: got out=%h sat=%0b, want out=0000 sat=0", mac_out, sat_flag);
    else n_pass++;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    set_op(2'd0, 16'd3, 16'd5, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    set_op(2'd0, 16'd2, 16'd7, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    set_idle();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL unsigned_early: got v=%0b, want v=0", out_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || mac_out !== 16'd15 || sat_flag !== 1'b0)
      $display("FAIL unsigned_op1: got v=%0b ch=%0d out=%h sat=%0b, want v=1 ch=0 out=000f sat=0",
               out_valid, out_ch, mac_out, sat_flag);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || mac_out !== 16'd29 || sat_flag !== 1'b0)
      $display("FAIL unsigned_op2: got v=%0b ch=%0d out=%h sat=%0b, want v=1 ch=0 out=001d sat=0",
               out_valid, out_ch, mac_out, sat_flag);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL unsigned_pulse: got v=%0b, want v=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_signed();
    set_op(2'd1, 16'hFFFE, 16'h0003, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    set_op(2'd1, 16'h0002, 16'h0003, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    set_idle();
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || mac_out !== 16'hFFFA || sat_flag !== 1'b0)
      $display("FAIL signed_op1: got v=%0b ch=%0d out=%h sat=%0b, want v=1 ch=1 out=fffa sat=0",
               out_valid, out_ch, mac_out, sat_flag);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || mac_out !== 16'h0000 || sat_flag !== 1'b0)
      $display("FAIL signed_op2: got v=%0b ch=%0d out=%h sat=%0b, want v=1 ch=1 out=0000 sat=0",
               out_valid, out_ch, mac_out, sat_flag);
    else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_op(2'd2, SAT_A[i], SAT_B[i], SAT_TC[i], 1'b1, 1'b0, SAT_K[i], SAT_S[i]);
      else set_idle();
      tick();
      if (i >= 2) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || mac_out !== SAT_Q[i-2] || sat_flag !== SAT_F[i-2])
          $display("FAIL sat_vec%0d: got v=%0b ch=%0d out=%h sat=%0b, want v=1 ch=2 out=%h sat=%0b",
                   i-2, out_valid, out_ch, mac_out, sat_flag, SAT_Q[i-2], SAT_F[i-2]);
        else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_round();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_op(2'd3, RND_A[i], RND_B[i], 1'b0, RND_C[i], 1'b1, RND_K[i], 1'b0);
      else set_idle();
      tick();
      if (i >= 2) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || mac_out !== RND_Q[i-2] || sat_flag !== 1'b0)
          $display("FAIL rnd_vec%0d: got v=%0b ch=%0d out=%h sat=%0b, want v=1 ch=3 out=%h sat=0",
                   i-2, out_valid, out_ch, mac_out, sat_flag, RND_Q[i-2]);
        else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_back_to_back_stall();
    set_op(2'd0, 16'd2, 16'd3, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    set_op(2'd1, 16'd4, 16'd5, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    en = 1'b0;
    set_op(2'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL stall_c1: got v=%0b, want v=0", out_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL stall_c2: got v=%0b, want v=0", out_valid);
    else n_pass++;
    en = 1'b1;
    set_op(2'd0, 16'd10, 16'd10, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || mac_out !== 16'd6)
      $display("FAIL ilv_op0: got v=%0b ch=%0d out=%0d, want v=1 ch=0 out=6", out_valid, out_ch, mac_out);
    else n_pass++;
    set_op(2'd1, 16'd7, 16'd1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || mac_out !== 16'd20)
      $display("FAIL ilv_op1: got v=%0b ch=%0d out=%0d, want v=1 ch=1 out=20", out_valid, out_ch, mac_out);
    else n_pass++;
    set_idle();
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || mac_out !== 16'd106)
      $display("FAIL ilv_op2: got v=%0b ch=%0d out=%0d, want v=1 ch=0 out=106", out_valid, out_ch, mac_out);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || mac_out !== 16'd27)
      $display("FAIL ilv_op3: got v=%0b ch=%0d out=%0d, want v=1 ch=1 out=27", out_valid, out_ch, mac_out);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL ilv_drain: got v=%0b, want v=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    set_op(2'd1, 16'd3, 16'd3, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    set_op(2'd1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    set_op(2'd1, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    set_idle();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || mac_out !== 16'd9)
      $display("FAIL rstmid_pre: got v=%0b ch=%0d out=%0d, want v=1 ch=1 out=9", out_valid, out_ch, mac_out);
    else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || mac_out !== 16'h0000 || sat_flag !== 1'b0)
      $display("FAIL rstmid_async: got v=%0b ch=%0d out=%h sat=%0b, want all 0",
               out_valid, out_ch, mac_out, sat_flag);
    else n_pass++;
    rstn = 1'b1;
    tick();
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_flush: got v=%0b, want v=0", out_valid);
    else n_pass++;
    set_op(2'd1, 16'd5, 16'd5, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    set_op(2'd0, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    set_idle();
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || mac_out !== 16'd25)
      $display("FAIL rstmid_ch1: got v=%0b ch=%0d out=%0d, want v=1 ch=1 out=25", out_valid, out_ch, mac_out);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || mac_out !== 16'd1)
      $display("FAIL rstmid_ch0: got v=%0b ch=%0d out=%0d, want v=1 ch=0 out=1", out_valid, out_ch, mac_out);
    else n_pass++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_saturation();
    test_round();
    test_back_to_back_stall();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
